// File: rtl/imem_stream_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into 32-bit words,
// writes them to instruction memory and releases the core only if the trailing XOR checksum matches.
module imem_stream_loader #(
    parameter int unsigned IMEM_ADDR_W = 9,
    parameter logic [63:0] BASE_ADDR   = 64'h0
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   start,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   rx_ready,
    output logic [63:0]            addr_ext,
    output logic                   wen_ext,
    output logic                   ren_ext,
    output logic [31:0]            wdata_ext,
    output logic                   cpu_enable,
    output logic                   busy,
    output logic                   error,
    output logic [IMEM_ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_RUN   = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [32:0] MAX_WORDS = 33'd1 << IMEM_ADDR_W;

    state_t               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [31:0]          len_q, len_d;
    logic [31:0]          word_q, word_d;
    logic [7:0]           csum_q, csum_d;
    logic [IMEM_ADDR_W:0] words_q, words_d;
    logic [63:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;

    logic                 rx_ready_s;
    logic                 xfer_s;
    logic [31:0]          len_full_s;
    logic                 len_over_s;
    logic [IMEM_ADDR_W:0] words_inc_s;

    assign xfer_s      = rx_valid & rx_ready_s;
    assign len_full_s  = {rx_data, len_q[31:8]};
    assign len_over_s  = ({1'b0, len_full_s} > MAX_WORDS);
    assign words_inc_s = words_q + {{IMEM_ADDR_W{1'b0}}, 1'b1};

    // State register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN;
                else       state_d = S_IDLE;
            end
            S_LEN: begin
                if (xfer_s && (cnt_q == 2'd3)) begin
                    if (len_over_s)                state_d = S_ERR;
                    else if (len_full_s == 32'd0)  state_d = S_CSUM;
                    else                           state_d = S_DATA;
                end else begin
                    state_d = S_LEN;
                end
            end
            S_DATA: begin
                if (xfer_s && (cnt_q == 2'd3)) state_d = S_WRITE;
                else                           state_d = S_DATA;
            end
            S_WRITE: begin
                if (32'(words_inc_s) == len_q) state_d = S_CSUM;
                else                           state_d = S_DATA;
            end
            S_CSUM: begin
                if (xfer_s) begin
                    if (rx_data == csum_q) state_d = S_RUN;
                    else                   state_d = S_ERR;
                end else begin
                    state_d = S_CSUM;
                end
            end
            S_RUN, S_ERR: begin
                if (start) state_d = S_LEN;
                else       state_d = state_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; pure function of state so arst clears every strobe immediately
    always_comb begin
        rx_ready_s = 1'b0;
        wen_ext    = 1'b0;
        cpu_enable = 1'b0;
        busy       = 1'b0;
        error      = 1'b0;
        case (state_q)
            S_LEN, S_DATA, S_CSUM: begin
                rx_ready_s = 1'b1;
                busy       = 1'b1;
            end
            S_WRITE: begin
                wen_ext = 1'b1;
                busy    = 1'b1;
            end
            S_RUN:   cpu_enable = 1'b1;
            S_ERR:   error      = 1'b1;
            default: rx_ready_s = 1'b0;
        endcase
    end

    // Datapath next-state: length/word assembly, running XOR, write address and data capture
    always_comb begin
        cnt_d   = cnt_q;
        len_d   = len_q;
        word_d  = word_q;
        csum_d  = csum_q;
        words_d = words_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    cnt_d   = 2'd0;
                    len_d   = 32'd0;
                    csum_d  = 8'd0;
                    words_d = '0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_LEN: begin
                if (xfer_s) begin
                    len_d  = len_full_s;
                    cnt_d  = cnt_q + 2'd1;
                    csum_d = csum_q ^ rx_data;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    word_d = {rx_data, word_q[31:8]};
                    cnt_d  = cnt_q + 2'd1;
                    csum_d = csum_q ^ rx_data;
                    if (cnt_q == 2'd3) begin
                        wdata_d = {rx_data, word_q[31:8]};
                        addr_d  = BASE_ADDR + 64'({words_q, 2'b00});
                    end else begin
                        wdata_d = wdata_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_WRITE: words_d = words_inc_s;
            default: cnt_d = cnt_q;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q   <= 2'd0;
            len_q   <= 32'd0;
            word_q  <= 32'd0;
            csum_q  <= 8'd0;
            words_q <= '0;
            addr_q  <= 64'd0;
            wdata_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            words_q <= words_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign rx_ready     = rx_ready_s;
    assign addr_ext     = addr_q;
    assign wdata_ext    = wdata_q;
    assign ren_ext      = 1'b0;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed + randomized sessions for imem_stream_loader, checked against a byte-list/write-list model.
module tb_imem_stream_loader;

    localparam int AW = 9;

    typedef logic [31:0] wq_t[$];

    logic          clk;
    logic          arst;
    logic          start;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic [63:0]   addr_ext;
    logic          wen_ext;
    logic          ren_ext;
    logic [31:0]   wdata_ext;
    logic          cpu_enable;
    logic          busy;
    logic          error;
    logic [AW:0]   words_loaded;

    int vectors     = 0;
    int miscompares = 0;

    logic [95:0] obs_q[$];

    imem_stream_loader #(.IMEM_ADDR_W(AW), .BASE_ADDR(64'h0)) dut (
        .clk          (clk),
        .arst         (arst),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .addr_ext     (addr_ext),
        .wen_ext      (wen_ext),
        .ren_ext      (ren_ext),
        .wdata_ext    (wdata_ext),
        .cpu_enable   (cpu_enable),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Capture every write strobe and watch cycle-level invariants
    always @(negedge clk) begin
        if (arst === 1'b0) begin
            check("err_en_exclusive", {63'd0, error & cpu_enable}, 64'd0);
            if (wen_ext) begin
                obs_q.push_back({addr_ext, wdata_ext});
                check("rx_ready_in_write", {63'd0, rx_ready}, 64'd0);
            end
        end
    end

    // Offer one byte until accepted; caller and callee sit just after a falling edge
    task automatic send_byte(input logic [7:0] b, input bit toggle);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("rx_ready_timeout", {63'd0, rx_ready}, 64'd1);
        @(negedge clk);
        if (toggle) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        check("error_after_start", {63'd0, error}, 64'd0);
    endtask

    // Reference: stream = LE length, LE words, XOR of everything before it; writes at 4*i
    task automatic run_session(input logic [31:0] n, input wq_t words, input bit bad,
                               input bit toggle, input bit start_mid);
        logic [7:0] bytes[$];
        logic [7:0] x;
        bit         len_ok;
        bit         ok;
        int         nw;
        len_ok = (n <= 32'd512);
        nw     = len_ok ? int'(n) : 0;
        x      = 8'd0;
        for (int k = 0; k < 4; k++) bytes.push_back(n[8*k +: 8]);
        if (len_ok) begin
            for (int i = 0; i < nw; i++)
                for (int k = 0; k < 4; k++) bytes.push_back(words[i][8*k +: 8]);
            foreach (bytes[i]) x = x ^ bytes[i];
            bytes.push_back(bad ? (x ^ 8'h01) : x);
        end
        ok = len_ok && !bad;
        obs_q.delete();
        start_pulse();
        foreach (bytes[i]) begin
            if (start_mid && i == 6) start = 1'b1;
            if (start_mid && i == 9) start = 1'b0;
            send_byte(bytes[i], toggle);
        end
        rx_valid = 1'b0;
        start    = 1'b0;
        check("cpu_enable_end", {63'd0, cpu_enable}, {63'd0, ok});
        check("error_end", {63'd0, error}, {63'd0, !ok});
        check("busy_end", {63'd0, busy}, 64'd0);
        check("words_loaded_end", 64'(words_loaded), 64'(nw));
        check("write_count", 64'(obs_q.size()), 64'(nw));
        for (int i = 0; i < nw && i < obs_q.size(); i++) begin
            check("write_addr", obs_q[i][95:32], 64'(4 * i));
            check("write_data", 64'(obs_q[i][31:0]), 64'(words[i]));
        end
    endtask

    initial begin
        wq_t w;
        arst     = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        #1;
        check("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
        check("rst_wen", {63'd0, wen_ext}, 64'd0);
        check("rst_ren", {63'd0, ren_ext}, 64'd0);
        check("rst_addr", addr_ext, 64'd0);
        check("rst_wdata", 64'(wdata_ext), 64'd0);
        check("rst_cpu_enable", {63'd0, cpu_enable}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);

        // Directed single word 00A00513, checksum B7 then B6
        w = {32'h00A00513};
        run_session(32'd1, w, 1'b0, 1'b0, 1'b0);
        run_session(32'd1, w, 1'b1, 1'b0, 1'b0);

        // Three random words with rx_valid toggling
        w = {};
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        run_session(32'd3, w, 1'b0, 1'b1, 1'b0);

        // Full memory at continuous rate
        w = {};
        for (int i = 0; i < 512; i++) w.push_back($urandom);
        run_session(32'd512, w, 1'b0, 1'b0, 1'b0);
        check("last_addr", obs_q.size() > 0 ? obs_q[obs_q.size()-1][95:32] : 64'd0, 64'h7FC);

        // One past capacity, empty image, start during DATA
        run_session(32'd513, w, 1'b0, 1'b0, 1'b0);
        w = {};
        run_session(32'd0, w, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) w.push_back($urandom);
        run_session(32'd4, w, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset with a partial word in flight
        obs_q.delete();
        start_pulse();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        rx_valid = 1'b0;
        arst     = 1'b1;
        #1;
        check("arst_rx_ready", {63'd0, rx_ready}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_wen", {63'd0, wen_ext}, 64'd0);
        check("arst_addr", addr_ext, 64'd0);
        check("arst_wdata", 64'(wdata_ext), 64'd0);
        check("arst_words", 64'(words_loaded), 64'd0);
        check("arst_error", {63'd0, error}, 64'd0);
        check("arst_cpu_enable", {63'd0, cpu_enable}, 64'd0);
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        w = {$urandom};
        run_session(32'd1, w, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Boot-time loader upstream of the CPU core.
- Accepts a byte stream (UART-receiver style valid/ready), assembles little-endian 32-bit instruction words and writes them into instruction memory through the core's external port (addr_ext/wen_ext/wdata_ext).
- Checks a trailing XOR checksum. Releases the core's enable only on success; holds it low on error.

Parameters:
- IMEM_ADDR_W, 9, instruction-memory word-address width; capacity = 2^IMEM_ADDR_W words.
- BASE_ADDR, 64'h0, byte address of the first written word.

Ports:
- clk  input  1  system clock, all state on rising edge
- arst  input  1  asynchronous reset, active-high
- start  input  1  begin a load session; sampled in IDLE, RUN, ERR
- rx_valid  input  1  stream byte valid
- rx_data  input  8  stream byte
- rx_ready  output  1  loader accepts byte; transfer = rx_valid & rx_ready
- addr_ext  output  64  instruction-memory byte address
- wen_ext  output  1  instruction-memory write strobe, one cycle per word
- ren_ext  output  1  constant 0
- wdata_ext  output  32  instruction word
- cpu_enable  output  1  drives core enable
- busy  output  1  high in LEN, DATA, WRITE, CSUM
- error  output  1  high in ERR
- words_loaded  output  IMEM_ADDR_W+1  words written this session

Behaviour:
- Reset (arst high, asynchronous): state=IDLE. All outputs 0: rx_ready, wen_ext, addr_ext, wdata_ext, cpu_enable, error, words_loaded. Byte counter, length and checksum registers cleared.
- Stream format: 4 length bytes N (little-endian, 32-bit), then 4*N data bytes (little-endian words), then 1 checksum byte C.
- Checksum rule: C must equal the XOR of all 4+4N preceding bytes.
- States:
  - IDLE: rx_ready=0. start=1 -> LEN; clear counters and checksum.
  - LEN: rx_ready=1. Collect 4 bytes; the first byte goes to N[7:0].
    - On the 4th transfer: N > 2^IMEM_ADDR_W -> ERR; N==0 -> CSUM; else -> DATA.
  - DATA: rx_ready=1. Shift bytes into the word assembler; the first byte goes to [7:0].
    - On the 4th byte of a word -> WRITE.
  - WRITE (one cycle): rx_ready=0, wen_ext=1, addr_ext=BASE_ADDR+4*words_loaded, wdata_ext=assembled word.
    - words_loaded increments at the end of this cycle.
    - Next state: CSUM if the new count equals N, else DATA.
  - CSUM: rx_ready=1. On transfer: byte == running XOR -> RUN, else -> ERR.
  - RUN: cpu_enable=1, rx_ready=0. start=1 -> LEN, with cpu_enable low from that edge.
  - ERR: error=1, cpu_enable=0, rx_ready=0. start=1 -> LEN, error cleared.
- Running XOR updates on every accepted length/data byte; the checksum byte itself is excluded.
- Write latency: wen_ext is asserted in the cycle immediately after the 4th byte of a word is accepted.
- Minimum cadence: 5 cycles per word at a continuous rx_valid.
- rx_valid low in LEN/DATA/CSUM: wait indefinitely, no state change.
- rx_data is ignored whenever rx_ready=0.
- start while busy: ignored.
- start is level-sampled; a held start in RUN/ERR restarts only once the FSM has left those states.
- wen_ext is never high outside WRITE. addr_ext and wdata_ext hold their last values outside WRITE.
- Address arithmetic: 64-bit unsigned. The word index is at most 2^IMEM_ADDR_W-1, so no wrap-around occurs.
- Boundary N = 2^IMEM_ADDR_W (512) is accepted and fills memory exactly. N = 513 -> ERR immediately after the length bytes, with zero writes.
- arst mid-session: immediate return to IDLE, wen_ext deasserted asynchronously, a partial word is discarded. Already-written words are not erased.
- error and cpu_enable are never high simultaneously.

Test Plan:
- Reset with arst pulsed mid-DATA -> all outputs 0 and state IDLE within the same cycle; a following start plus a valid 1-word stream loads correctly.
- start, then bytes 01 00 00 00, 13 05 A0 00, checksum B7 -> one wen_ext pulse with addr_ext=0, wdata_ext=32'h00A00513; then RUN, cpu_enable=1, words_loaded=1.
- Same stream with checksum B6 -> the word is still written, state goes to ERR, error=1, cpu_enable=0; a subsequent start clears error.
- N=3 with rx_valid toggling 1/0 every cycle -> three writes at addresses 0, 4, 8 with correct words; no byte lost or duplicated; rx_ready low during each WRITE.
- Length 00 02 00 00 (512), 2048 data bytes, correct checksum -> last write at addr 0x7FC, words_loaded=512, RUN. Length 01 02 00 00 (513) -> ERR after the 4th byte, no wen_ext.
- N=0 with checksum 00 -> RUN with no writes. start pulsed during DATA -> ignored, session completes normally.
